board_state: RTL and testbench

BOARD_STATE -- requirements
Module: board_state

---
 rtl/board_state.sv | 125 ++++++++++++
 tb/tb_board_state.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/board_state.sv
// rtl/board_state.sv - checkers board image with a move-legality FSM
// Optional king support is selected with the BOARD_KING_EN macro.
module board_state (
  input  logic         clk,
  input  logic         reset,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   from_sq,
  input  logic [5:0]   to_sq,
  output logic         done,
  output logic         move_ok,
  output logic         turn,
  output logic [255:0] boardBuffer
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, DONE} state_t;

  state_t       state, state_n;
  logic [5:0]   from_r, to_r, mid_r, mid_sq;
  logic         legal_r, jump_r;
  logic [3:0]   piece_r, piece, src;
  logic [1:0]   mid;
  logic         dst_occ, step, jump, dir_ok, legal, crown;
  logic [2:0]   fc, fr, tc, tr;
  logic [3:0]   col_sum, row_sum;
  logic signed [3:0] dcol, drow;

  function automatic logic [255:0] init_board();
    logic [255:0] b;
    b = '0;
    for (int s = 0; s < 64; s++) begin
      if (((s % 8) + (s / 8)) % 2 == 1) begin
        if (s / 8 <= 2)      b[4*s +: 4] = 4'b0011;
        else if (s / 8 >= 5) b[4*s +: 4] = 4'b0001;
      end
    end
    return b;
  endfunction

  // Column/row differences come from the 3-bit fields so edge wraps never look adjacent.
  always_comb begin
    fc      = from_r[2:0];
    fr      = from_r[5:3];
    tc      = to_r[2:0];
    tr      = to_r[5:3];
    dcol    = $signed({1'b0, tc}) - $signed({1'b0, fc});
    drow    = $signed({1'b0, tr}) - $signed({1'b0, fr});
    col_sum = {1'b0, fc} + {1'b0, tc};
    row_sum = {1'b0, fr} + {1'b0, tr};
    mid_sq  = {row_sum[3:1], col_sum[3:1]};
    src     = boardBuffer[{from_r, 2'b00} +: 4];
    dst_occ = boardBuffer[{to_r, 2'b00}];
    mid     = boardBuffer[{mid_sq, 2'b00} +: 2];
    step    = (dcol == 4'sd1 || dcol == -4'sd1) && (drow == 4'sd1 || drow == -4'sd1);
    jump    = (dcol == 4'sd2 || dcol == -4'sd2) && (drow == 4'sd2 || drow == -4'sd2)
              && mid[0] && (mid[1] != turn);
`ifdef BOARD_KING_EN
    dir_ok  = src[2] || (src[1] ? (drow > 4'sd0) : (drow < 4'sd0));
    crown   = src[1] ? (tr == 3'd7) : (tr == 3'd0);
    piece   = (src & 4'b0111) | {1'b0, crown, 2'b00};
`else
    dir_ok  = src[1] ? (drow > 4'sd0) : (drow < 4'sd0);
    crown   = 1'b0;
    piece   = (src & 4'b0011) | {1'b0, crown, 2'b00};
`endif
    legal   = src[0] && (src[1] == turn) && !dst_occ && dir_ok && (step || jump);
  end

  always_comb begin
    state_n    = state;
    move_ready = 1'b0;
    done       = 1'b0;
    move_ok    = 1'b0;
    case (state)
      IDLE: begin
        move_ready = 1'b1;
        if (move_valid) state_n = CHECK;
      end
      CHECK: state_n = APPLY;
      APPLY: state_n = DONE;
      DONE: begin
        done    = 1'b1;
        move_ok = legal_r;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      boardBuffer <= init_board();
      turn        <= 1'b0;
      from_r      <= '0;
      to_r        <= '0;
      mid_r       <= '0;
      legal_r     <= 1'b0;
      jump_r      <= 1'b0;
      piece_r     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (move_valid) begin
          from_r <= from_sq;
          to_r   <= to_sq;
        end
        CHECK: begin
          legal_r <= legal;
          jump_r  <= jump;
          mid_r   <= mid_sq;
          piece_r <= piece;
        end
        APPLY: if (legal_r) begin
          boardBuffer[{from_r, 2'b00} +: 4] <= 4'b0000;
          if (jump_r) boardBuffer[{mid_r, 2'b00} +: 4] <= 4'b0000;
          boardBuffer[{to_r, 2'b00} +: 4] <= piece_r;
          turn <= ~turn;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state.sv
// tb/tb_board_state.sv - directed self-checking bench for board_state
module tb_board_state;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         move_valid = 1'b0;
  logic         move_ready;
  logic [5:0]   from_sq = '0;
  logic [5:0]   to_sq = '0;
  logic         done;
  logic         move_ok;
  logic         turn;
  logic [255:0] boardBuffer;

  int tests = 0;
  int fails = 0;
  logic [255:0] init_b;
  logic [255:0] exp_board;
  logic         exp_turn;

  board_state dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_ready(move_ready),
    .from_sq(from_sq), .to_sq(to_sq), .done(done), .move_ok(move_ok),
    .turn(turn), .boardBuffer(boardBuffer)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [255:0] b, input int s);
    return b[4*s +: 4];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected board after a legal move, worked from the square numbers alone.
  function automatic logic [255:0] moved(input logic [255:0] b, input int f, input int t);
    logic [255:0] r;
    r = b;
    r[4*t +: 4] = b[4*f +: 4];
    r[4*f +: 4] = 4'b0000;
    if ((t / 8 - f / 8 == 2) || (f / 8 - t / 8 == 2))
      r[4*(((f % 8) + (t % 8)) / 2 + 8 * (((f / 8) + (t / 8)) / 2)) +: 4] = 4'b0000;
    return r;
  endfunction

  task automatic do_move(input string tag, input int f, input int t, input logic exp_ok);
    @(negedge clk);
    from_sq    = 6'(f);
    to_sq      = 6'(t);
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_chk_ready"}, 256'(move_ready), 256'(1'b0));
    chk({tag, "_chk_done"}, 256'(done), 256'(1'b0));
    @(negedge clk);
    chk({tag, "_apply_done"}, 256'(done), 256'(1'b0));
    chk({tag, "_apply_board"}, boardBuffer, exp_board);
    @(negedge clk);
    chk({tag, "_done"}, 256'(done), 256'(1'b1));
    chk({tag, "_ok"}, 256'(move_ok), 256'(exp_ok));
    if (exp_ok) begin
      exp_board = moved(exp_board, f, t);
      exp_turn  = ~exp_turn;
    end
    chk({tag, "_board"}, boardBuffer, exp_board);
    chk({tag, "_turn"}, 256'(turn), 256'(exp_turn));
    @(negedge clk);
    chk({tag, "_idle_ready"}, 256'(move_ready), 256'(1'b1));
    chk({tag, "_idle_done"}, 256'(done), 256'(1'b0));
    chk({tag, "_idle_ok"}, 256'(move_ok), 256'(1'b0));
  endtask

  initial begin
    init_b = '0;
    for (int s = 0; s < 64; s++)
      if (((s % 8) + (s / 8)) % 2 == 1) begin
        if (s / 8 <= 2)      init_b[4*s +: 4] = 4'b0011;
        else if (s / 8 >= 5) init_b[4*s +: 4] = 4'b0001;
      end
    exp_board = init_b;
    exp_turn  = 1'b0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_sq1", 256'(nib(boardBuffer, 1)), 256'(4'b0011));
    chk("rst_sq40", 256'(nib(boardBuffer, 40)), 256'(4'b0001));
    chk("rst_sq32", 256'(nib(boardBuffer, 32)), 256'(4'b0000));
    chk("rst_board", boardBuffer, init_b);
    chk("rst_turn", 256'(turn), 256'(1'b0));
    chk("rst_ready", 256'(move_ready), 256'(1'b1));
    chk("rst_done", 256'(done), 256'(1'b0));
    chk("rst_ok", 256'(move_ok), 256'(1'b0));

    do_move("m40_33", 40, 33, 1'b1);
    chk("m40_33_sq40", 256'(nib(boardBuffer, 40)), 256'(4'b0000));
    chk("m40_33_sq33", 256'(nib(boardBuffer, 33)), 256'(4'b0001));
    do_move("m49_40_wrong_turn", 49, 40, 1'b0);
    do_move("m23_24_wrap", 23, 24, 1'b0);
    do_move("m19_26", 19, 26, 1'b1);
    do_move("m33_19_jump", 33, 19, 1'b1);
    chk("jump_sq26", 256'(nib(boardBuffer, 26)), 256'(4'b0000));
    chk("jump_sq33", 256'(nib(boardBuffer, 33)), 256'(4'b0000));
    chk("jump_sq19", 256'(nib(boardBuffer, 19)), 256'(4'b0001));
    chk("jump_turn", 256'(turn), 256'(1'b1));
    do_move("m17_17_same", 17, 17, 1'b0);
    do_move("m21_39_empty_mid", 21, 39, 1'b0);
    do_move("m17_8_backward", 17, 8, 1'b0);
    do_move("m17_24_occupied_ok", 17, 24, 1'b1);

    // Reset lands during CHECK of 40->33 while move_valid is held high.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_board = init_b;
    exp_turn  = 1'b0;
    @(negedge clk);
    from_sq    = 6'd40;
    to_sq      = 6'd33;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_check", 256'(move_ready), 256'(1'b0));
    reset      = 1'b1;
    move_valid = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    move_valid = 1'b0;
    chk("abort_ready", 256'(move_ready), 256'(1'b1));
    chk("abort_board", boardBuffer, init_b);
    chk("abort_turn", 256'(turn), 256'(1'b0));
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 256'(done), 256'(1'b0));
      chk("abort_board_hold", boardBuffer, init_b);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
